product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the pipelined multiplier. Takes a stream of 2*WIDTH-bit products, one per accepted beat, and sums each vector into a dot-product result.
- A vector ends on in_last, or automatically after MAX_LEN beats. The finished sum is then held under a valid/ready handshake until the sink takes it.

Parameters:
- WIDTH, 8, multiplier operand width; the product input is 2*WIDTH bits.
- ACC_WIDTH, 2*WIDTH+8, accumulator and result width; must be >= 2*WIDTH.
- MAX_LEN, 16, maximum beats per vector; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_product  in  2*WIDTH  unsigned product.
- in_last  in  1  final beat of the current vector.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- out_sum  out  ACC_WIDTH  accumulated sum.
- out_count  out  $clog2(MAX_LEN+1)  number of beats in the vector.
- out_ovf  out  1  an overflow occurred during this vector.

Behaviour:
- Reset is asynchronous. State goes to IDLE; acc, count, ovf, out_sum, out_count and out_ovf all go to 0; out_valid=0, in_ready=1.
- Reset mid-vector discards the partial sum with no output. After reset the next vector starts from zero.
- A beat is accepted when in_valid && in_ready at a rising edge. in_ready = (state != DONE).
- States:
  - IDLE: no partial sum held.
  - ACCUM: partial sum held.
  - DONE: result held on the outputs.
- IDLE, on accept:
  - acc = zero-extended product, count = 1, ovf = 0.
  - Go to DONE if in_last or MAX_LEN==1, else ACCUM.
- ACCUM, on accept:
  - acc = acc + zero-extended product, count = count + 1.
  - A carry out of ACC_WIDTH sets ovf (sticky for this vector).
  - Go to DONE if in_last or the new count == MAX_LEN, else stay in ACCUM.
- ACCUM with no accept (in_valid low): hold everything, no timeout.
- Entering DONE, the same edge that accepts the final beat loads:
  - out_sum = the final sum including that beat;
  - out_count = the final count;
  - out_ovf = the final ovf.
- Latency: out_valid is high in the cycle immediately after the edge that accepts the last beat.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_sum, out_count and out_ovf are stable while out_ready=0.
  - On out_ready, go to IDLE at that edge. out_valid drops and in_ready rises the next cycle.
  - There is exactly one bubble cycle between vectors. in_valid during DONE is ignored and not consumed.
- out_sum, out_count and out_ovf keep their last values in IDLE and ACCUM; only out_valid qualifies them.
- in_last on a beat with count < MAX_LEN terminates the vector early.
- Reaching MAX_LEN without in_last terminates the vector. The next beat starts a new vector.
- Arithmetic is unsigned modulo 2^ACC_WIDTH (unless SAT_EN is defined).
- No combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- Defined: on carry out, acc clamps to 2^ACC_WIDTH-1 and stays there for the rest of the vector. ovf is still set.
- Undefined: acc wraps modulo 2^ACC_WIDTH and ovf is set.

Test Plan:
- WIDTH=8, ACC_WIDTH=24, MAX_LEN=4. Send products 10, 20, 30 with in_last on 30 -> out_valid=1 the cycle after the third accept; out_sum=60, out_count=3, out_ovf=0.
- Same config. Send 4 beats of product 1, no in_last -> auto-terminate; out_sum=4, out_count=4. A fifth beat of 7 with in_last, after handshake -> out_sum=7, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no beats consumed. Raise out_ready -> IDLE next cycle, and the pending beat is accepted one cycle later.
- ACC_WIDTH=16. Send 65025, 65025 with in_last:
  - without the macro -> out_sum=64514, out_ovf=1;
  - with PRODUCT_ACC_SAT_EN -> out_sum=65535, out_ovf=1.
- Gaps and single beat: in_valid toggles 1,0,0,1 with products 5, 9 (last) -> out_sum=14, out_count=2. A single beat 0xFE01 with in_last -> out_sum=65025, out_count=1.
- Assert rst asynchronously after 2 of 3 beats -> out_valid=0 and in_ready=1 immediately. A new vector 3, 4 (last) -> out_sum=7, out_count=2.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned multiplier products into one dot-product result per vector.
// Define PRODUCT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int MAX_LEN   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*WIDTH-1:0]             in_product,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
  output logic                           out_ovf
);

  localparam int CNT_W = $clog2(MAX_LEN+1);
  localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_LEN);

  localparam logic [1:0] LP_IDLE  = 2'd0;
  localparam logic [1:0] LP_ACCUM = 2'd1;
  localparam logic [1:0] LP_DONE  = 2'd2;

`ifdef PRODUCT_ACC_SAT_EN
  localparam bit LP_SAT = 1'b1;
`else
  localparam bit LP_SAT = 1'b0;
`endif

  // Carry-out either wraps or pins the accumulator at full scale.
  function automatic logic [ACC_WIDTH-1:0] f_sat(input logic [ACC_WIDTH:0] sum);
    return (sum[ACC_WIDTH] && LP_SAT) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  endfunction

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_addend;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_next_acc;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_next_ovf;
  logic                 w_term;

  assign in_ready  = (r_state != LP_DONE);
  assign out_valid = (r_state == LP_DONE);
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_addend   = ACC_WIDTH'(in_product);
    w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
    w_next_acc = w_addend;
    w_next_cnt = CNT_W'(1);
    w_next_ovf = 1'b0;
    if (r_state == LP_ACCUM) begin
      w_next_acc = f_sat(w_sum);
      w_next_cnt = r_count + CNT_W'(1);
      w_next_ovf = r_ovf | w_sum[ACC_WIDTH];
    end
    // Covers MAX_LEN==1 too: the first beat already reaches the limit.
    w_term = in_last || (w_next_cnt == LP_MAX_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LP_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        LP_IDLE, LP_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_next_acc;
            r_count <= w_next_cnt;
            r_ovf   <= w_next_ovf;
            if (w_term) begin
              r_state     <= LP_DONE;
              r_out_sum   <= w_next_acc;
              r_out_count <= w_next_cnt;
              r_out_ovf   <= w_next_ovf;
            end else begin
              r_state <= LP_ACCUM;
            end
          end
        end
        LP_DONE: begin
          if (out_ready) r_state <= LP_IDLE;
        end
        default: r_state <= LP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed scoreboard bench for product_accumulator (24-bit and 16-bit accumulator instances).
module tb_product_accumulator;

  typedef struct {
    longint sum;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_last, a_ov, a_or, a_ovf;
  logic [15:0] a_prod;
  logic [23:0] a_sum;
  logic [2:0]  a_cnt;
  logic        b_iv, b_ir, b_last, b_ov, b_or, b_ovf;
  logic [15:0] b_prod;
  logic [15:0] b_sum;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_ovf[2];

  product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .MAX_LEN(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_product(a_prod),
    .in_last(a_last), .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum),
    .out_count(a_cnt), .out_ovf(a_ovf));

  product_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .MAX_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_product(b_prod),
    .in_last(b_last), .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum),
    .out_count(b_cnt), .out_ovf(b_ovf));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: integer accumulation, then wrap or clamp against the instance's range.
  function automatic void model_beat(input int d, input longint p, input bit last);
    longint lim;
    exp_t   e;
    lim = (d == 0) ? 64'sd16777216 : 64'sd65536;
    if (m_cnt[d] == 0) begin
      m_acc[d] = p;
      m_cnt[d] = 1;
      m_ovf[d] = 1'b0;
    end else begin
      m_acc[d] = m_acc[d] + p;
      m_cnt[d] = m_cnt[d] + 1;
      if (m_acc[d] >= lim) begin
        m_ovf[d] = 1'b1;
`ifdef PRODUCT_ACC_SAT_EN
        m_acc[d] = lim - 1;
`else
        m_acc[d] = m_acc[d] - lim;
`endif
      end
    end
    if (last || m_cnt[d] == 4) begin
      e.sum = m_acc[d];
      e.cnt = m_cnt[d];
      e.ovf = m_ovf[d];
      if (d == 0) q_a.push_back(e);
      else q_b.push_back(e);
      m_cnt[d] = 0;
    end
  endfunction

  task automatic beat(input int d, input logic [15:0] p, input logic last);
    logic rdy;
    rdy = (d == 0) ? a_ir : b_ir;
    chk("in_ready_before_beat", rdy, 1'b1);
    if (d == 0) begin a_iv = 1'b1; a_prod = p; a_last = last; end
    else begin b_iv = 1'b1; b_prod = p; b_last = last; end
    @(posedge clk);
    if (rdy) model_beat(d, p, last);
    @(negedge clk);
    if (d == 0) begin a_iv = 1'b0; a_last = 1'b0; end
    else begin b_iv = 1'b0; b_last = 1'b0; end
  endtask

  task automatic collect(input int d, input string tag);
    exp_t e;
    logic ov, ovf;
    logic [63:0] sum, cnt;
    int qs;
    if (d == 0) begin ov = a_ov; ovf = a_ovf; sum = 64'(a_sum); cnt = 64'(a_cnt); qs = q_a.size(); end
    else begin ov = b_ov; ovf = b_ovf; sum = 64'(b_sum); cnt = 64'(b_cnt); qs = q_b.size(); end
    chk({tag, "_valid"}, ov, 1'b1);
    chk({tag, "_queue"}, (qs > 0), 1'b1);
    if (qs > 0) begin
      e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
      chk({tag, "_sum"}, sum, e.sum);
      chk({tag, "_count"}, cnt, e.cnt);
      chk({tag, "_ovf"}, ovf, e.ovf);
    end
    if (d == 0) a_or = 1'b1; else b_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (d == 0) a_or = 1'b0; else b_or = 1'b0;
    chk({tag, "_idle_valid"}, (d == 0) ? a_ov : b_ov, 1'b0);
    chk({tag, "_idle_ready"}, (d == 0) ? a_ir : b_ir, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_last = 1'b0; a_or = 1'b0; a_prod = '0;
    b_iv = 1'b0; b_last = 1'b0; b_or = 1'b0; b_prod = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    #12;
    chk("rst_valid", a_ov, 1'b0);
    chk("rst_ready", a_ir, 1'b1);
    chk("rst_sum", a_sum, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_ovf", a_ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Early termination with in_last
    beat(0, 16'd10, 1'b0);
    beat(0, 16'd20, 1'b0);
    beat(0, 16'd30, 1'b1);
    chk("t1_sum_const", a_sum, 60);
    collect(0, "t1");

    // Auto-terminate at MAX_LEN, then a fresh single-beat vector
    for (int i = 0; i < 4; i++) beat(0, 16'd1, 1'b0);
    chk("t2_count_const", a_cnt, 4);
    collect(0, "t2");
    beat(0, 16'd7, 1'b1);
    collect(0, "t2b");

    // Backpressure: pending beat held during DONE must not be consumed
    beat(0, 16'd2, 1'b0);
    beat(0, 16'd3, 1'b1);
    a_iv = 1'b1; a_prod = 16'd9; a_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", a_ov, 1'b1);
      chk("bp_in_ready", a_ir, 1'b0);
      chk("bp_sum", a_sum, 5);
      chk("bp_count", a_cnt, 2);
    end
    collect(0, "bp");
    @(posedge clk);
    model_beat(0, 9, 1'b1);
    @(negedge clk);
    a_iv = 1'b0; a_last = 1'b0;
    collect(0, "bp_next");

    // Gaps between beats, then a single full-scale beat
    beat(0, 16'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    beat(0, 16'd9, 1'b1);
    collect(0, "gap");
    beat(0, 16'hFE01, 1'b1);
    collect(0, "single");

    // Asynchronous reset mid-vector
    beat(0, 16'd1, 1'b0);
    beat(0, 16'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a_ov, 1'b0);
    chk("arst_ready", a_ir, 1'b1);
    chk("arst_sum", a_sum, 0);
    chk("arst_count", a_cnt, 0);
    m_cnt[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    beat(0, 16'd3, 1'b0);
    beat(0, 16'd4, 1'b1);
    collect(0, "post_rst");

    // Overflow on the 16-bit accumulator
    beat(1, 16'd65025, 1'b0);
    beat(1, 16'd65025, 1'b1);
`ifdef PRODUCT_ACC_SAT_EN
    chk("ovf16_sum_const", b_sum, 65535);
`else
    chk("ovf16_sum_const", b_sum, 64514);
`endif
    chk("ovf16_flag_const", b_ovf, 1'b1);
    collect(1, "ovf16");

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
